// File: rtl/shamt_ext_arbiter.sv
// -----------------------------------------------------------------------------
// shamt_ext_arbiter
//
// Shares a single registered 5-to-32-bit zero-extension path among NUM_REQ
// cores. Each cycle the output slot is free, a round-robin arbiter picks one
// requesting core, pulses its Grant bit, and loads the zero-extended field
// (tagged with the core ID) into the output register.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Rst       in   asynchronous active-low reset
//   Req       in   [NUM_REQ]            per-core request, held until Grant
//   FieldIn   in   [NUM_REQ*IN_WIDTH]   packed fields, core i at [i*IN_WIDTH +: IN_WIDTH]
//   OutReady  in   consumer accepts Out this cycle
//   Grant     out  [NUM_REQ]            one-cycle one-hot acceptance pulse
//   Out       out  [OUT_WIDTH]          zero-extended field of the winner
//   OutCore   out  [log2(NUM_REQ)]      ID of the core owning Out
//   OutValid  out  Out/OutCore valid
// -----------------------------------------------------------------------------
module shamt_ext_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int IN_WIDTH  = 5,
  parameter int OUT_WIDTH = 32,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  FieldIn,
  input  logic                         OutReady,
  output logic [NUM_REQ-1:0]           Grant,
  output logic [OUT_WIDTH-1:0]         Out,
  output logic [ID_W-1:0]              OutCore,
  output logic                         OutValid
);

  logic [NUM_REQ-1:0]   grant_q,     grant_d;
  logic [OUT_WIDTH-1:0] out_q,       out_d;
  logic [ID_W-1:0]      out_core_q,  out_core_d;
  logic                 out_valid_q, out_valid_d;
  logic [ID_W-1:0]      ptr_q,       ptr_d;

  logic                 slot_free;
  logic [NUM_REQ-1:0]   eligible;
  logic                 found;
  logic [ID_W-1:0]      win;
  logic [ID_W-1:0]      idx;
  logic [IN_WIDTH-1:0]  win_field;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    slot_free   = !out_valid_q || OutReady;
    // A core being granted this cycle still shows Req high; mask it so the
    // same request is not accepted twice.
    eligible    = Req & ~grant_q;
    found       = 1'b0;
    win         = '0;
    idx         = '0;

    // Scan Ptr, Ptr+1, ... wrapping; ID_W-bit addition wraps for free since
    // NUM_REQ is a power of two.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + ID_W'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    win_field   = FieldIn[win*IN_WIDTH +: IN_WIDTH];

    out_d       = out_q;
    out_core_d  = out_core_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    grant_d     = '0;            // Grant is a pulse; stalls and idle cycles drop it

    if (slot_free) begin
      if (found) begin
        out_d        = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, win_field};
        out_core_d   = win;
        out_valid_d  = 1'b1;
        grant_d[win] = 1'b1;
        ptr_d        = win + ID_W'(1);
      end else begin
        out_valid_d  = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      grant_q     <= '0;
      out_q       <= '0;
      out_core_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      grant_q     <= grant_d;
      out_q       <= out_d;
      out_core_q  <= out_core_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign Grant    = grant_q;
  assign Out      = out_q;
  assign OutCore  = out_core_q;
  assign OutValid = out_valid_q;

endmodule

// File: tb/tb_shamt_ext_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shamt_ext_arbiter
//
// Self-checking bench for shamt_ext_arbiter: a table of directed vectors,
// hand-written sequences for reset, wrap-around and zero-extension, and a
// randomized phase compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_shamt_ext_arbiter;

  localparam int N  = 8;
  localparam int IW = 5;
  localparam int OW = 32;

  logic          Clk;
  logic          Rst;
  logic [N-1:0]  Req;
  logic [N*IW-1:0] FieldIn;
  logic          OutReady;
  logic [N-1:0]  Grant;
  logic [OW-1:0] Out;
  logic [2:0]    OutCore;
  logic          OutValid;

  int total = 0;
  int bad   = 0;

  shamt_ext_arbiter #(.NUM_REQ(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Req      (Req),
    .FieldIn  (FieldIn),
    .OutReady (OutReady),
    .Grant    (Grant),
    .Out      (Out),
    .OutCore  (OutCore),
    .OutValid (OutValid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_field(input int core, input logic [IW-1:0] v);
    FieldIn[core*IW +: IW] = v;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0]  req;
    logic          rdy;
    logic [N-1:0]  g;
    logic [OW-1:0] o;
    int            c;
    logic          v;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [N-1:0] req, input logic rdy,
                              input logic [N-1:0] g, input logic [OW-1:0] o,
                              input int c, input logic v);
    vec_t t;
    t.req = req; t.rdy = rdy; t.g = g; t.o = o; t.c = c; t.v = v;
    tbl.push_back(t);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: pointer, output slot and last grant as plain integers.
  // ---------------------------------------------------------------------------
  int            m_ptr;
  bit            m_valid;
  int            m_core;
  logic [OW-1:0] m_out;
  logic [N-1:0]  m_grant;
  int            waits [N];

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_core = 0; m_out = '0; m_grant = '0;
    for (int j = 0; j < N; j++) waits[j] = 0;
  endtask

  // Evaluate one clock edge using the inputs that were present before it.
  task automatic model_step();
    int w;
    bit free;
    free = !m_valid || OutReady;
    w = -1;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && Req[i] && !m_grant[i]) w = i;
      end
    end
    if (w >= 0) begin
      // Fairness: no request waits through more than N-1 accepted transactions.
      check($sformatf("fair core%0d", w), waits[w], (waits[w] <= N-1) ? waits[w] : N-1);
      for (int j = 0; j < N; j++)
        if (Req[j] && j != w) waits[j]++;
      waits[w] = 0;
      m_out   = FieldIn[w*IW +: IW];   // implicit zero extension
      m_core  = w;
      m_valid = 1;
      m_grant = '0;
      m_grant[w] = 1'b1;
      m_ptr   = (w + 1) % N;
    end else begin
      m_grant = '0;
      if (free) m_valid = 0;
    end
    for (int j = 0; j < N; j++)
      if (!Req[j]) waits[j] = 0;
  endtask

  task automatic compare_model(input int cyc);
    check($sformatf("rnd%0d grant", cyc), Grant, m_grant);
    check($sformatf("rnd%0d valid", cyc), OutValid, m_valid);
    check($sformatf("rnd%0d upper", cyc), Out[OW-1:IW], 0);
    if (m_valid) begin
      check($sformatf("rnd%0d out", cyc), Out, m_out);
      check($sformatf("rnd%0d core", cyc), OutCore, m_core);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [IW-1:0] base_f [N];

  initial begin
    base_f = '{5'h03, 5'h11, 5'h16, 5'h09, 5'h04, 5'h1F, 5'h00, 5'h15};

    Rst      = 1'b0;
    Req      = '0;
    OutReady = 1'b1;
    for (int i = 0; i < N; i++) set_field(i, base_f[i]);

    step();
    step();
    check("reset grant", Grant, 0);
    check("reset out",   Out, 0);
    check("reset core",  OutCore, 0);
    check("reset valid", OutValid, 0);
    Rst = 1'b1;

    // Directed table (pointer starts at 0).
    add(8'h04, 1, 8'h04, 32'h16, 2, 1);  // single request, core 2
    add(8'h00, 1, 8'h00, 32'h0,  0, 0);  // drop -> valid low
    add(8'h20, 1, 8'h20, 32'h1F, 5, 1);  // field 11111 -> 0000001F
    add(8'h00, 1, 8'h00, 32'h0,  0, 0);
    add(8'h82, 1, 8'h80, 32'h15, 7, 1);  // ptr=6, cores {7,1}: 7 first
    add(8'h02, 1, 8'h02, 32'h11, 1, 1);  // then 1
    add(8'h00, 1, 8'h00, 32'h0,  0, 0);
    add(8'h08, 1, 8'h08, 32'h09, 3, 1);  // grant core 3
    add(8'h10, 0, 8'h00, 32'h09, 3, 1);  // stall x3 with Req[4] high
    add(8'h10, 0, 8'h00, 32'h09, 3, 1);
    add(8'h10, 0, 8'h00, 32'h09, 3, 1);
    add(8'h10, 1, 8'h10, 32'h04, 4, 1);  // released -> core 4
    add(8'h00, 1, 8'h00, 32'h0,  0, 0);
    add(8'h02, 1, 8'h02, 32'h11, 1, 1);  // ptr=5 -> core 1
    add(8'h22, 1, 8'h20, 32'h1F, 5, 1);  // core 1 still high, masked -> 5
    add(8'h00, 1, 8'h00, 32'h0,  0, 0);
    add(8'h02, 1, 8'h02, 32'h11, 1, 1);  // ptr=6 -> core 1
    add(8'h02, 1, 8'h00, 32'h0,  0, 0);  // sole request masked: no re-grant
    add(8'h00, 1, 8'h00, 32'h0,  0, 0);
    add(8'hFF, 1, 8'h04, 32'h16, 2, 1);  // ptr=2, all requesting
    add(8'hFF, 1, 8'h08, 32'h09, 3, 1);
    add(8'hFF, 1, 8'h10, 32'h04, 4, 1);
    add(8'hFF, 1, 8'h20, 32'h1F, 5, 1);
    add(8'hFF, 1, 8'h40, 32'h00, 6, 1);
    add(8'hFF, 1, 8'h80, 32'h15, 7, 1);
    add(8'hFF, 1, 8'h01, 32'h03, 0, 1);
    add(8'hFF, 1, 8'h02, 32'h11, 1, 1);
    add(8'hFF, 1, 8'h04, 32'h16, 2, 1);
    add(8'h00, 1, 8'h00, 32'h0,  0, 0);

    foreach (tbl[i]) begin
      Req      = tbl[i].req;
      OutReady = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d grant", i), Grant, tbl[i].g);
      check($sformatf("tbl%0d valid", i), OutValid, tbl[i].v);
      if (tbl[i].v) begin
        check($sformatf("tbl%0d out", i), Out, tbl[i].o);
        check($sformatf("tbl%0d core", i), OutCore, tbl[i].c);
      end
    end

    // Asynchronous reset while OutValid is high.
    Req = 8'h01;
    step();
    check("pre-rst valid", OutValid, 1);
    check("pre-rst core",  OutCore, 0);
    Req = '0;
    Rst = 1'b0;
    #1;
    check("async rst grant", Grant, 0);
    check("async rst out",   Out, 0);
    check("async rst core",  OutCore, 0);
    check("async rst valid", OutValid, 0);
    Rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("idle%0d grant", c), Grant, 0);
      check($sformatf("idle%0d out", c),   Out, 0);
      check($sformatf("idle%0d core", c),  OutCore, 0);
      check($sformatf("idle%0d valid", c), OutValid, 0);
    end

    // Round-robin from Ptr=0 with every core requesting: 0..7 then 0.
    Req = 8'hFF;
    for (int c = 0; c < 9; c++) begin
      int e;
      logic [N-1:0] oh;
      e  = c % N;
      oh = '0;
      oh[e] = 1'b1;
      step();
      check($sformatf("rr%0d grant", c), Grant, oh);
      check($sformatf("rr%0d core", c),  OutCore, e);
      check($sformatf("rr%0d out", c),   Out, {27'd0, base_f[e]});
    end
    Req = '0;
    step();
    check("rr end valid", OutValid, 0);

    // Zero field still produces a valid result.
    set_field(5, 5'h00);
    Req = 8'h20;
    step();
    check("zero-field valid", OutValid, 1);
    check("zero-field out",   Out, 0);
    check("zero-field core",  OutCore, 5);
    Req = '0;
    step();
    set_field(5, base_f[5]);

    // Randomized phase against the reference model.
    Rst = 1'b0;
    #1;
    Rst = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) set_field(i, IW'($urandom));
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (Req[i] && m_grant[i]) begin
          // Served: usually drop, sometimes keep high as a fresh request.
          if ($urandom_range(0, 3) != 0) Req[i] = 1'b0;
        end else if (Req[i]) begin
          if ($urandom_range(0, 15) == 0) Req[i] = 1'b0;  // withdraw
        end else if ($urandom_range(0, 9) < 4) begin
          set_field(i, IW'($urandom));
          Req[i] = 1'b1;
        end
      end
      OutReady = ($urandom_range(0, 3) != 0);
      step();
      model_step();
      compare_model(cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
